alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// ALU execute stage: one-deep registered result with valid/ready on both sides.
// Default build: every operation completes in one cycle through a barrel shifter.
// Macro ALU_SERIAL_SHIFT_EN: SLL/SRL/SRA with a non-zero amount run serially,
// one bit per cycle, in the SHIFT state; all other operations stay single-cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on the same side; valid must not depend on ready, and a producer holds
// its payload until the transfer edge.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            dbg_state_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_CSR  = 4'd11;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [4:0]      shamt;
  logic            transfer;
  logic            out_free;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam logic [1:0] SK_SLL = 2'd0;
  localparam logic [1:0] SK_SRL = 2'd1;
  localparam logic [1:0] SK_SRA = 2'd2;

  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] sh_q, sh_d, sh_next;
  logic [1:0]      kind_q, kind_d;
  logic            is_shift;
`endif

  assign shamt       = op_b[4:0];
  assign out_free    = !out_valid_q || out_ready;
  assign in_ready    = (state_q != SHIFT) && out_free;
  assign transfer    = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

  // Single-cycle ALU datapath; in serial mode shifts only cover amount 0 here.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_SERIAL_SHIFT_EN
      OP_SLL:  alu_res = op_a;
      OP_SRA:  alu_res = op_a;
      OP_SRL:  alu_res = op_a;
`else
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SRL:  alu_res = op_a >> shamt;
`endif
      OP_PASS: alu_res = op_b;
      OP_CSR:  alu_res = op_a;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  // One-bit step of the serial shifter for the latched shift kind.
  always_comb begin
    sh_next = sh_q;
    case (kind_q)
      SK_SLL:  sh_next = {sh_q[XLEN-2:0], 1'b0};
      SK_SRL:  sh_next = {1'b0, sh_q[XLEN-1:1]};
      default: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
    endcase
  end

  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) ||
                    (alu_ctrl == OP_SRA);
`endif

  // Next-state: output register drain/load and the IDLE/SHIFT sequencing.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
`ifdef ALU_SERIAL_SHIFT_EN
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    kind_d      = kind_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef ALU_SERIAL_SHIFT_EN
    if (transfer && is_shift && (shamt != 5'd0)) begin
      state_d = SHIFT;
      cnt_d   = shamt;
      sh_d    = op_a;
      kind_d  = (alu_ctrl == OP_SLL) ? SK_SLL :
                (alu_ctrl == OP_SRL) ? SK_SRL : SK_SRA;
    end else if (transfer) begin
      result_d    = alu_res;
      illegal_d   = alu_ill;
      out_valid_d = 1'b1;
    end
    // The final step waits if the previous result is still stalled downstream.
    if (state_q == SHIFT && ((cnt_q != 5'd1) || out_free)) begin
      sh_d  = sh_next;
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        result_d    = sh_next;
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
    end
`else
    if (transfer) begin
      result_d    = alu_res;
      illegal_d   = alu_ill;
      out_valid_d = 1'b1;
    end
    state_d = IDLE;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      cnt_q       <= '0;
      sh_q        <= '0;
      kind_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
`ifdef ALU_SERIAL_SHIFT_EN
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      kind_q      <= kind_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed corner cases plus random traffic
// with random downstream back-pressure, checked against an expected queue.
// Define ALU_SERIAL_SHIFT_EN to also exercise the serial shifter.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;
  logic        dbg_state_o;

  logic [31:0] exp_q[$];
  logic        exp_ill_q[$];
  int          n_checks;
  int          n_errors;
  logic        rand_mode;
  logic        forced_ready;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctrl   (alu_ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .illegal    (illegal),
    .dbg_state_o(dbg_state_o)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent reference model: returns {illegal, result}.
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    r = 32'h0;
    ill = 1'b0;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a + ~b + 32'd1;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[30:0], 1'b0}; end
      4'd6: r = {31'h0, (a[31] != b[31]) ? a[31] : (a < b)};
      4'd7: r = {31'h0, (a < b)};
      4'd8: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]}; end
      4'd9: begin r = a; for (int i = 0; i < int'(b[4:0]); i++) r = {1'b0, r[31:1]}; end
      4'd10: r = b;
      4'd11: r = a;
      default: begin r = 32'h0; ill = 1'b1; end
    endcase
    return {ill, r};
  endfunction

  // Downstream ready driver: random back-pressure or a forced level.
  always begin
    @(negedge clk);
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : forced_ready;
  end

  // Scoreboard: compare every consumed result against the expected queue.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {31'h0, out_valid}, 32'h0);
      end else begin
        check("result", result, exp_q.pop_front());
        check("illegal", {31'h0, illegal}, {31'h0, exp_ill_q.pop_front()});
      end
    end
  end

  // Offer one operation; returns cycles spent waiting for in_ready.
  // Returns #1 after the transfer edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      output int waited);
    logic [32:0] m;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a = a;
    op_b = b;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 200) check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    m = model(c, a, b);
    exp_q.push_back(m[31:0]);
    exp_ill_q.push_back(m[32]);
    #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom_range(0, 15));
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain", exp_q.size(), 32'h0);
  endtask

  initial begin
    int w;
    int cyc;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    alu_ctrl = 4'h0;
    op_a = 32'h0;
    op_b = 32'h0;
    rand_mode = 1'b0;
    forced_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_illegal", {31'h0, illegal}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_state", {31'h0, dbg_state_o}, 32'h0);

    // ADD wrap, latency one cycle.
    send(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, w);
    check("add_latency_valid", {31'h0, out_valid}, 32'h1);
    check("add_result", result, 32'h0);
    check("add_illegal", {31'h0, illegal}, 32'h0);
    send(4'd6, 32'h8000_0000, 32'h0000_0001, w);
    send(4'd7, 32'h8000_0000, 32'h0000_0001, w);
    send(4'd8, 32'h8000_0000, 32'h0000_0024, w);
    send(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, w);
    send(4'd10, 32'hDEAD_BEEF, 32'h1234_5000, w);
    send(4'd11, 32'h0000_00A5, 32'h5555_5555, w);
    drain();

    // Downstream stall: result and flags held, input side blocked.
    forced_ready = 1'b0;
    @(negedge clk);
    send(4'd1, 32'd5, 32'd7, w);
    check("stall_first_result", result, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check("stall_result_hold", result, 32'hFFFF_FFFE);
      check("stall_valid_hold", {31'h0, out_valid}, 32'h1);
      check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    end
    forced_ready = 1'b1;
    send(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, w);
    check("accept_on_ready_wait", w, 32'h0);
    drain();

`ifdef ALU_SERIAL_SHIFT_EN
    // Serial SLL by 31: one cycle per bit.
    send(4'd5, 32'h1, 32'd31, w);
    check("serial_in_shift", {31'h0, dbg_state_o}, 32'h1);
    check("serial_in_ready_low", {31'h0, in_ready}, 32'h0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("serial_latency", cyc, 32'd31);
    check("serial_result", result, 32'h8000_0000);
    drain();
    // Reset in the middle of a long shift abandons it.
    send(4'd5, 32'h1, 32'd31, w);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_ill_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("shift_rst_valid", {31'h0, out_valid}, 32'h0);
    check("shift_rst_state", {31'h0, dbg_state_o}, 32'h0);
    check("shift_rst_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (40) begin
      @(negedge clk);
      #2;
      if (out_valid) check("shift_rst_no_result", {31'h0, out_valid}, 32'h0);
    end
`else
    cyc = 0;
`endif

    // Random traffic with random back-pressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom, w);
    end
    rand_mode = 1'b0;
    forced_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
